// File: rtl/gbfwei_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gbfwei_rd_ctrl
// Purpose  : Read controller behind the weight global buffer (GBFWEI) RAM.
//            Takes burst commands (base address, length) and issues reads to
//            the single-port RAM. Read data returns one cycle after the read
//            is issued. The returned word goes into a small skid FIFO and is
//            streamed to the PE array over valid/ready, with a last flag.
//            A read is issued only when a FIFO slot is guaranteed for its
//            data, so backpressure never loses a returning word.
//
// Ports    : clk            sole clock
//            rst            synchronous active-high reset
//            cmd_valid/cmd_ready/cmd_addr/cmd_len   burst command handshake
//            gbf_wr_busy    write port owns the RAM address mux this cycle
//            ram_read_en    RAM read enable (combinational)
//            ram_addr_r     RAM read address (combinational, 0 when idle)
//            ram_data_out   RAM read data, valid the cycle after ram_read_en
//            out_valid/out_ready/out_data/out_last  weight word stream
//            done           one-cycle pulse at burst completion
//            stall_cnt      [15:0] saturating stall counter (optional)
//
// Options  : GBFWEI_RD_STAT_EN  when defined, adds the stall_cnt output
//
// Revision : 1.0  initial release
// ============================================================================
module gbfwei_rd_ctrl #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_WIDTH     = 28,
    parameter int LEN_WIDTH      = 7,
    parameter int FIFO_DEPTH_BIT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [SRAM_DEPTH_BIT-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic                      gbf_wr_busy,
    output logic                      ram_read_en,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
    input  logic [SRAM_WIDTH-1:0]     ram_data_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SRAM_WIDTH-1:0]     out_data,
    output logic                      out_last,
    output logic                      done
`ifdef GBFWEI_RD_STAT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int c_fifo_depth = 1 << FIFO_DEPTH_BIT;
    // FIFO depth expressed in the width of the credit arithmetic below.
    localparam logic [FIFO_DEPTH_BIT+1:0] c_credit_lim =
        {1'b0, 1'b1, {FIFO_DEPTH_BIT{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [SRAM_DEPTH_BIT-1:0]   r_addr;
    logic [LEN_WIDTH-1:0]        r_remaining;
    logic                        r_inflight;
    logic                        r_inflight_last;
    logic                        r_zero_done;

    // Skid FIFO: each entry holds {last tag, data word}.
    logic [SRAM_WIDTH:0]         r_fifo_mem [c_fifo_depth];
    logic [FIFO_DEPTH_BIT-1:0]   r_wr_ptr;
    logic [FIFO_DEPTH_BIT-1:0]   r_rd_ptr;
    logic [FIFO_DEPTH_BIT:0]     r_count;

    logic                        w_cmd_fire;
    logic                        w_push;
    logic                        w_pop;
    logic [FIFO_DEPTH_BIT+1:0]   w_credit_used;
    logic                        w_credit_ok;
    logic                        w_issue;
    logic                        w_drain_done;
    logic [SRAM_WIDTH:0]         w_head;

    // ------------------------------------------------------------------
    // Handshakes and credit accounting
    // ------------------------------------------------------------------
    assign w_cmd_fire = cmd_valid & cmd_ready;
    assign w_pop      = out_valid & out_ready;
    // Returning data is pushed unconditionally; the credit check is what
    // makes that safe. A pop in the same cycle frees a slot immediately,
    // which keeps one word per cycle flowing with only two entries.
    assign w_push     = r_inflight;

    // Slots already spoken for: stored words plus the word in flight,
    // minus the one leaving this cycle. Never negative, since a pop needs
    // a stored word.
    assign w_credit_used = {1'b0, r_count}
                         + {{(FIFO_DEPTH_BIT+1){1'b0}}, r_inflight}
                         - {{(FIFO_DEPTH_BIT+1){1'b0}}, w_pop};
    assign w_credit_ok   = (w_credit_used < c_credit_lim);

    assign w_issue = (r_state == S_RUN) && (r_remaining != '0)
                   && !gbf_wr_busy && w_credit_ok;

    // Finishing from DRAIN needs the last word to have left the FIFO in an
    // earlier cycle. That places done one cycle after the final pop.
    assign w_drain_done = (r_state == S_DRAIN) && !r_inflight
                        && (r_count == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and RAM-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        ram_read_en = 1'b0;
        ram_addr_r  = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                // A zero-length command is only acknowledged through done.
                if (cmd_valid && (cmd_len != '0)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                ram_read_en = w_issue;
                ram_addr_r  = w_issue ? r_addr : '0;
                if (w_issue && (r_remaining == LEN_WIDTH'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign done = r_zero_done | w_drain_done;

    // ------------------------------------------------------------------
    // Burst counters and in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_zero_done     <= 1'b0;
        end else begin
            r_zero_done     <= w_cmd_fire && (cmd_len == '0);
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == LEN_WIDTH'(1));
            if (w_cmd_fire && (cmd_len != '0)) begin
                r_addr      <= cmd_addr;
                r_remaining <= cmd_len;
            end else if (w_issue) begin
                // The address wraps at the top of the buffer, so a
                // full-length burst visits every word exactly once.
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Skid FIFO storage (contents need no reset; occupancy gates use)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {r_inflight_last, ram_data_out};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output stream; data and last read as zero while the FIFO is empty
    // ------------------------------------------------------------------
    assign w_head    = r_fifo_mem[r_rd_ptr];
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? w_head[SRAM_WIDTH-1:0] : '0;
    assign out_last  = out_valid & w_head[SRAM_WIDTH];

`ifdef GBFWEI_RD_STAT_EN
    // ------------------------------------------------------------------
    // Stall statistics: downstream backpressure or a read lost to the
    // write port, counted only while a burst is active.
    // ------------------------------------------------------------------
    logic [15:0] r_stall_cnt;
    logic        w_stall_evt;

    assign w_stall_evt = ((r_state == S_RUN) || (r_state == S_DRAIN))
                       && ((out_valid && !out_ready)
                           || ((r_state == S_RUN) && (r_remaining != '0)
                               && gbf_wr_busy));

    always_ff @(posedge clk) begin
        if (rst || w_cmd_fire) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // Statistics build option disabled: no stall counter is present.
`endif

endmodule
`default_nettype wire

// File: tb/tb_gbfwei_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gbfwei_rd_ctrl
// Purpose  : Scoreboard bench for gbfwei_rd_ctrl. Commands push expected
//            read addresses, output words and done pulses into queues.
//            Independent monitors pop and compare whenever the DUT shows a
//            read, a transferred word or a done pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_gbfwei_rd_ctrl;

    localparam int AW = 6;
    localparam int DW = 28;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          gbf_wr_busy;
    logic          ram_read_en;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_data_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
`ifdef GBFWEI_RD_STAT_EN
    logic [15:0]   stall_cnt;
`endif

    gbfwei_rd_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .gbf_wr_busy  (gbf_wr_busy),
        .ram_read_en  (ram_read_en),
        .ram_addr_r   (ram_addr_r),
        .ram_data_out (ram_data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .done         (done)
`ifdef GBFWEI_RD_STAT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int issued = 0;
    int popped = 0;
    bit sb_en  = 1'b1;

    logic [DW-1:0] mem [64];

    typedef struct { logic [DW-1:0] data; logic last; int cyc; } word_t;
    typedef struct { logic [AW-1:0] addr; int cyc; } addr_t;
    word_t data_q[$];
    addr_t addr_q[$];
    int    done_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // RAM model: one-cycle read latency.
    initial forever begin
        @(posedge clk);
        if (ram_read_en) ram_data_out <= mem[ram_addr_r];
    end

    // Cycle counter and outstanding-read bookkeeping.
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        if (rst) begin
            issued <= 0;
            popped <= 0;
        end else begin
            if (ram_read_en) issued <= issued + 1;
            if (out_valid && out_ready) popped <= popped + 1;
        end
    end

    // Read-address and output-word monitor.
    initial begin
        bit            hold_v;
        logic [DW-1:0] hold_d;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!rst && sb_en) begin
                if (ram_read_en) begin
                    check("read_while_busy", {31'd0, gbf_wr_busy}, 32'd0);
                    if (addr_q.size() == 0) begin
                        check("unexpected_read", 32'd1, 32'd0);
                    end else begin
                        addr_t a;
                        a = addr_q.pop_front();
                        check("rd_addr", {26'd0, ram_addr_r}, {26'd0, a.addr});
                        if (a.cyc >= 0) check("rd_addr_cycle", cyc, a.cyc);
                    end
                end
                if (hold_v) begin
                    check("hold_valid", {31'd0, out_valid}, 32'd1);
                    check("hold_data", {4'd0, out_data}, {4'd0, hold_d});
                end
                if (out_valid && out_ready) begin
                    if (data_q.size() == 0) begin
                        check("unexpected_word", 32'd1, 32'd0);
                    end else begin
                        word_t w;
                        w = data_q.pop_front();
                        check("out_data", {4'd0, out_data}, {4'd0, w.data});
                        check("out_last", {31'd0, out_last}, {31'd0, w.last});
                        if (w.cyc >= 0) check("out_cycle", cyc, w.cyc);
                    end
                end
                check("outstanding_le_2", {31'd0, (issued - popped) > 2}, 32'd0);
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // Done-pulse monitor (runs even while the scoreboard is paused).
    initial forever begin
        @(negedge clk);
        if (!rst && done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                int e;
                e = done_q.pop_front();
                if (e >= 0) check("done_cycle", cyc, e);
            end
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input int len,
                            input bit timed, input bit push);
        int c;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = LW'(len);
        for (int t = 0; t < 200 && !cmd_ready; t++) @(negedge clk);
        if (!cmd_ready) check("cmd_accept_timeout", 32'd0, 32'd1);
        c = cyc;
        if (push) begin
            for (int i = 0; i < len; i++) begin
                int idx;
                idx = (int'(a) + i) % 64;
                addr_q.push_back('{AW'(idx), timed ? c + 1 + i : -1});
                data_q.push_back('{mem[idx], (i == len - 1), timed ? c + 3 + i : -1});
            end
            done_q.push_back((len == 0) ? c + 1 : (timed ? c + 3 + len : -1));
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (data_q.size() == 0 && addr_q.size() == 0 && done_q.size() == 0)
                break;
        end
        check("drain_leftover", data_q.size() + addr_q.size() + done_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        check({tag, "_ram_read_en"}, {31'd0, ram_read_en}, 32'd0);
        check({tag, "_ram_addr_r"}, {26'd0, ram_addr_r}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_data"}, {4'd0, out_data}, 32'd0);
        check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = DW'(32'h0A50000 + i * 32'h1011);
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        gbf_wr_busy = 1'b0;
        out_ready   = 1'b1;
        ram_data_out = '0;

        // Two cycles of reset, then reset-value checks.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Exact latency: reads C+1..C+4, words C+3..C+6, done C+7.
        send_cmd(6'h05, 4, 1'b1, 1'b1);
        wait_idle();

        // Address wrap at the top of the buffer.
        send_cmd(6'h3E, 4, 1'b1, 1'b1);
        wait_idle();

        // Backpressure toggling plus a 3-cycle write-port busy window.
        send_cmd(6'h20, 6, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            out_ready   = ((i % 4) == 0) || ((i % 4) == 3);
            gbf_wr_busy = (i >= 4) && (i <= 6);
            @(posedge clk);
            #1;
        end
        out_ready   = 1'b1;
        gbf_wr_busy = 1'b0;
        wait_idle();

        // Zero-length command: done one cycle later, no reads, still ready.
        send_cmd(6'h11, 0, 1'b1, 1'b1);
        @(negedge clk);
        check("len0_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        wait_idle();

        // Full-buffer burst from 0x10, one word per cycle, last is mem[0x0F].
        send_cmd(6'h10, 64, 1'b1, 1'b1);
        wait_idle();

        // Reset two cycles into a length-10 burst.
        sb_en = 1'b0;
        send_cmd(6'h08, 10, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midreset_no_word", {31'd0, out_valid}, 32'd0);
        end
        sb_en = 1'b1;

        // Normal operation after the aborted burst.
        send_cmd(6'h30, 3, 1'b1, 1'b1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gbfwei_rd_ctrl.md
Name: gbfwei_rd_ctrl

Overview:
- Read controller directly downstream of the weight global buffer (GBFWEI) RAM.
- Accepts burst commands (base address, length) and issues read_en/addr_r to the single-port GBFWEI RAM.
- Captures the 1-cycle-latency read data into a small skid FIFO and streams 28-bit weight words to the PE array over a valid/ready handshake with a last flag.
- Read issue is credit-limited, so no returning word is ever dropped under downstream backpressure.

Parameters:
- SRAM_DEPTH_BIT, 6: GBFWEI address width; the buffer holds 2**SRAM_DEPTH_BIT words.
- SRAM_WIDTH, 28: weight word width.
- LEN_WIDTH, 7: burst length field width; legal lengths are 0..2**SRAM_DEPTH_BIT.
- FIFO_DEPTH_BIT, 1: skid FIFO holds 2**FIFO_DEPTH_BIT entries; minimum is 1.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  controller can accept a command.
- cmd_addr  in  SRAM_DEPTH_BIT  burst base address.
- cmd_len  in  LEN_WIDTH  number of words in the burst.
- gbf_wr_busy  in  1  GBFWEI write port active this cycle; the write owns the address mux.
- ram_read_en  out  1  to RAM read_en.
- ram_addr_r  out  SRAM_DEPTH_BIT  to RAM addr_r.
- ram_data_out  in  SRAM_WIDTH  from RAM data_out; valid the cycle after ram_read_en.
- out_valid  out  1  weight word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  SRAM_WIDTH  weight word.
- out_last  out  1  final word of the burst.
- done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0 except cmd_ready=1. FIFO is emptied; in-flight flag, counters and state are cleared.
- FSM IDLE:
  - cmd_ready=1.
  - A handshake with cmd_len>0 latches addr and remaining=cmd_len, then goes to RUN.
  - A handshake with cmd_len==0 pulses done the next cycle, issues no read, and stays in IDLE.
- FSM RUN:
  - cmd_ready=0.
  - A read issues when remaining>0, gbf_wr_busy=0, and (occupancy + inflight - pop) < 2**FIFO_DEPTH_BIT, where pop = out_valid & out_ready in the same cycle.
  - On issue: ram_read_en=1, ram_addr_r=addr, addr increments modulo 2**SRAM_DEPTH_BIT (63 wraps to 0), remaining decrements, inflight is set for the next cycle.
  - When remaining hits 0, go to DRAIN.
- FSM DRAIN: wait until inflight=0 and the last word is popped. Then pulse done for one cycle and return to IDLE. cmd_ready rises in the cycle after the done pulse.
- ram_read_en and ram_addr_r are combinational from state and counters.
- Capture: in the cycle after an issue (inflight=1), ram_data_out is written into the FIFO at the clock edge.
- Output: out_valid = FIFO not empty. out_data is the FIFO head.
- out_last = head is the burst's final word. A tag bit is stored per entry, set for the word issued with remaining==1.
- Latency: command handshake in cycle C, first ram_read_en in C+1, out_valid in C+3.
- Throughput: sustained 1 word/cycle with out_ready=1 and gbf_wr_busy=0, FIFO_DEPTH_BIT>=1.
- gbf_wr_busy high: no issue that cycle. Data already in flight is still captured.
- out_ready low: FIFO holds and out_data is stable. Issue stops once credits are exhausted, so no overflow.
- Simultaneous push and pop with the FIFO full: allowed only when a credit was reserved, so occupancy is unchanged.
- Length 2**SRAM_DEPTH_BIT reads the full buffer once, wrapping from the base address.
- Reset mid-burst: everything is aborted. A RAM word returning after reset is discarded, and done is not pulsed.
- cmd_valid while cmd_ready=0: ignored and not latched.

Optional Feature:
- Macro: GBFWEI_RD_STAT_EN.
- Defined: adds output stall_cnt [15:0].
  - Increments each RUN/DRAIN cycle where out_valid=1 and out_ready=0, or where a read was blocked by gbf_wr_busy.
  - Saturates at 0xFFFF.
  - Cleared by rst and on each command handshake.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- rst high for 2 cycles, then cmd addr=0x05 len=4 with out_ready=1 -> ram_addr_r reads 5,6,7,8 on C+1..C+4; out_data is mem[5..8] on C+3..C+6; out_last only with mem[8]; done pulses on C+7.
- cmd addr=0x3E len=4 -> addresses 0x3E,0x3F,0x00,0x01; output order matches.
- len=6 with out_ready toggling 1,0,0,1… and gbf_wr_busy=1 for 3 cycles mid-burst -> all 6 words delivered exactly once, in order, no read issued while busy; FIFO occupancy never exceeds 2.
- cmd len=0 -> no ram_read_en; done pulses 1 cycle after the handshake; cmd_ready stays 1.
- len=64 at addr=0x10 with out_ready=1 -> 64 consecutive words, one per cycle; last word is mem[0x0F].
- rst asserted 2 cycles into a len=10 burst -> all outputs return to reset values the next cycle, done never pulses, and the next command behaves normally.
